// File: rtl/display_share_scheduler_if.sv
// Display-share bus: requester inputs, converter handshake and display outputs.
// The scheduler takes the slave side; the requester/display environment
// takes the master side.
interface display_share_scheduler_if #(
    parameter int N    = 16,
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] req_value;
    logic [NREQ-1:0]   req_fmt;
    logic              bcd_idle;
    logic              bcd_trigger;
    logic [N-1:0]      to_display;
    logic              display_format;
    logic [NREQ-1:0]   grant;
    logic              blank;

    modport master (
        output req, req_value, req_fmt, bcd_idle,
        input  bcd_trigger, to_display, display_format, grant, blank
    );

    modport slave (
        input  req, req_value, req_fmt, bcd_idle,
        output bcd_trigger, to_display, display_format, grant, blank
    );
endinterface

// File: rtl/display_share_scheduler.sv
// Round-robin sharing of one seven-segment display path between NREQ
// requesters. Each grant is held for at least HOLD_CYCLES clocks, and
// decimal requests are sequenced through the external BCD converter
// before they are shown.
module display_share_scheduler #(
    parameter int N           = 16,
    parameter int NREQ        = 4,
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic                      clk,
    input  logic                      reset,
    display_share_scheduler_if.slave  bus
);
    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HCW = $clog2(HOLD_CYCLES);
    localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLD_CYCLES - 1);
    localparam logic [PW-1:0]  LAST_IDX  = PW'(NREQ - 1);

    typedef enum logic [1:0] {IDLE, CONVERT, SHOW} state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [HCW-1:0]  hold_cnt_q, hold_cnt_d;
    logic [N-1:0]    val_q, val_d;
    logic            fmt_q, fmt_d;
    logic [N-1:0]    disp_q, disp_d;
    logic            dfmt_q, dfmt_d;
    logic            blank_q, blank_d;
    logic            trig_q, trig_d;

    logic [N-1:0]    vals [NREQ];
    logic            win_found;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   scan_idx;
    logic            arb;

    // Unpack the flat requester value bus so the winner can be selected by index.
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign vals[g] = bus.req_value[g*N +: N];
    end

    // Round-robin scan: first set req at or above rr_ptr, wrapping to 0.
    // Since rr_ptr sits just past the current owner, the owner is scanned last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int off = 0; off < NREQ; off++) begin
            scan_idx = PW'((int'(rr_ptr_q) + off) % NREQ);
            if (!win_found && bus.req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    // Next-state and datapath updates; arb marks an arbitration point that found a winner.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        val_d      = val_q;
        fmt_d      = fmt_q;
        disp_d     = disp_q;
        dfmt_d     = dfmt_q;
        blank_d    = blank_q;
        trig_d     = 1'b0;
        arb        = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_found) arb = 1'b1;
            end
            CONVERT: begin
                // trig_q high marks the trigger cycle; bcd_idle then still reflects
                // the previous conversion and is ignored.
                if (!trig_q && bus.bcd_idle) begin
                    state_d    = SHOW;
                    hold_cnt_d = HOLD_LOAD;
                    disp_d     = val_q;
                    dfmt_d     = fmt_q;
                    blank_d    = 1'b0;
                end
            end
            SHOW: begin
                if (hold_cnt_q != '0) begin
                    hold_cnt_d = hold_cnt_q - HCW'(1);
                end else if (win_found) begin
                    arb = 1'b1;
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                    blank_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                blank_d = 1'b1;
            end
        endcase

        // Grant (or refresh) the winner: latch its value/format now so later
        // changes on req_value are ignored until the next arbitration point.
        if (arb) begin
            grant_d  = NREQ'(1) << win_idx;
            rr_ptr_d = (win_idx == LAST_IDX) ? '0 : win_idx + PW'(1);
            val_d    = vals[win_idx];
            fmt_d    = bus.req_fmt[win_idx];
            if (bus.req_fmt[win_idx]) begin
                state_d = CONVERT;
                trig_d  = 1'b1;
            end else begin
                state_d    = SHOW;
                hold_cnt_d = HOLD_LOAD;
                disp_d     = vals[win_idx];
                dfmt_d     = 1'b0;
                blank_d    = 1'b0;
            end
        end
    end

    // State register; reset abandons any conversion in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            hold_cnt_q <= '0;
            val_q      <= '0;
            fmt_q      <= 1'b0;
            disp_q     <= '0;
            dfmt_q     <= 1'b0;
            blank_q    <= 1'b1;
            trig_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_cnt_q <= hold_cnt_d;
            val_q      <= val_d;
            fmt_q      <= fmt_d;
            disp_q     <= disp_d;
            dfmt_q     <= dfmt_d;
            blank_q    <= blank_d;
            trig_q     <= trig_d;
        end
    end

    assign bus.bcd_trigger    = trig_q;
    assign bus.to_display     = disp_q;
    assign bus.display_format = dfmt_q;
    assign bus.grant          = grant_q;
    assign bus.blank          = blank_q;
endmodule

// File: tb/tb_display_share_scheduler.sv
// Directed bench for display_share_scheduler with HOLD_CYCLES=4.
// A vector table covers hex sharing, round-robin and a decimal conversion;
// hand-written sequences cover mid-hold value changes and async reset.
module tb_display_share_scheduler;
    localparam int N    = 16;
    localparam int NREQ = 4;

    typedef struct {
        logic [3:0]  req;
        logic        idle;
        logic [3:0]  g;
        logic [15:0] d;
        logic        b;
        logic        f;
        logic        t;
        logic        cd;   // 1 = check to_display/display_format
    } vec_t;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;
    vec_t tv[$];

    display_share_scheduler_if #(.N(N), .NREQ(NREQ)) bus ();

    display_share_scheduler #(.N(N), .NREQ(NREQ), .HOLD_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic row(input logic [3:0] req, input logic idle, input logic [3:0] g,
                       input logic [15:0] d, input logic b, input logic f,
                       input logic t, input logic cd);
        vec_t v;
        v.req = req; v.idle = idle; v.g = g; v.d = d;
        v.b = b; v.f = f; v.t = t; v.cd = cd;
        tv.push_back(v);
    endtask

    task automatic chk_outs(input string tag, input logic [3:0] g, input logic [15:0] d,
                            input logic b, input logic f, input logic t, input logic cd);
        chk({tag, " grant"}, 32'(bus.grant), 32'(g));
        chk({tag, " blank"}, 32'(bus.blank), 32'(b));
        chk({tag, " trigger"}, 32'(bus.bcd_trigger), 32'(t));
        if (cd) begin
            chk({tag, " to_display"}, 32'(bus.to_display), 32'(d));
            chk({tag, " format"}, 32'(bus.display_format), 32'(f));
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;

        // Each row: inputs during a cycle, outputs expected after its rising edge.
        //   req     idle  grant    display   b     f     t     cd
        row(4'b0000, 1'b0, 4'b0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1); // r0 idle
        // hex single, refresh of the lone owner
        for (int i = 0; i < 5; i++)
            row(4'b0001, 1'b0, 4'b0001, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b1);
        // round-robin over 1011
        for (int i = 0; i < 3; i++)
            row(4'b1011, 1'b0, 4'b0001, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            row(4'b1011, 1'b0, 4'b0010, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            row(4'b1011, 1'b0, 4'b1000, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b1);
        row(4'b1011, 1'b0, 4'b0001, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b1);  // r17
        // owner drops req in its 2nd show cycle: hold not shortened
        row(4'b0001, 1'b0, 4'b0001, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b1);
        row(4'b0000, 1'b0, 4'b0001, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b1);
        row(4'b0000, 1'b0, 4'b0001, 16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b1);
        row(4'b0000, 1'b0, 4'b0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0); // r21 idle
        // decimal: trigger, idle during trigger cycle ignored, 4 busy cycles
        row(4'b0100, 1'b0, 4'b0100, 16'hBEEF, 1'b1, 1'b0, 1'b1, 1'b1);
        row(4'b0100, 1'b1, 4'b0100, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            row(4'b0100, 1'b0, 4'b0100, 16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            row(4'b0100, 1'b1, 4'b0100, 16'h04D2, 1'b0, 1'b1, 1'b0, 1'b1);
        // decimal refresh from SHOW: display kept while converting
        row(4'b0100, 1'b1, 4'b0100, 16'h04D2, 1'b0, 1'b1, 1'b1, 1'b1);
        row(4'b0000, 1'b1, 4'b0100, 16'h04D2, 1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
            row(4'b0000, 1'b1, 4'b0100, 16'h04D2, 1'b0, 1'b1, 1'b0, 1'b1);
        row(4'b0000, 1'b0, 4'b0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0); // back to idle

        bus.req       = '0;
        bus.req_fmt   = 4'b0100;
        bus.req_value = {16'h3333, 16'd1234, 16'h1111, 16'hBEEF};
        bus.bcd_idle  = 1'b0;
        reset         = 1'b0;
        repeat (2) tick();
        chk_outs("reset", 4'b0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        reset = 1'b1;

        foreach (tv[i]) begin
            bus.req      = tv[i].req;
            bus.bcd_idle = tv[i].idle;
            tick();
            chk_outs($sformatf("row%0d", i), tv[i].g, tv[i].d, tv[i].b, tv[i].f,
                     tv[i].t, tv[i].cd);
        end

        // value change mid-hold is ignored until the refresh
        bus.req_fmt   = 4'b0000;
        bus.bcd_idle  = 1'b0;
        bus.req_value = {16'h3333, 16'd1234, 16'h1111, 16'h0001};
        bus.req       = 4'b0001;
        tick();
        chk_outs("chg show1", 4'b0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        bus.req_value = {16'h3333, 16'd1234, 16'h1111, 16'h0002};
        chk_outs("chg show2", 4'b0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk_outs("chg show3", 4'b0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk_outs("chg show4", 4'b0001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        chk_outs("chg refresh", 4'b0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1);

        // async reset mid-SHOW, no clock edge in between
        #2 reset = 1'b0;
        #1 chk_outs("async rst show", 4'b0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        bus.req = '0;
        @(negedge clk) reset = 1'b1;
        tick();
        chk_outs("after rst", 4'b0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);

        // async reset during the trigger cycle drops the pulse at once
        bus.req_fmt = 4'b0100;
        bus.req     = 4'b0100;
        tick();
        chk_outs("trig", 4'b0100, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
        #2 reset = 1'b0;
        #1 chk_outs("async rst conv", 4'b0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        bus.req = '0;
        @(negedge clk) reset = 1'b1;
        tick();
        chk_outs("idle end", 4'b0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
